voice_mixer: RTL and testbench



---
 rtl/voice_mixer.sv | 191 +++++++++++++++++++
 tb/tb_voice_mixer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// voice_mixer: serial gain-weighted mixer feeding the PmodI2S output stage.
//
// Once per SAMPLE_DIV clocks the voice, gain and enable inputs are captured.
// The voices are then accumulated one per cycle through a single multiplier,
// and the limited result is registered into sig with a one-cycle sample_valid.
//
// Ports:
//   clk           500 MHz system clock
//   rst_n         synchronous active-low reset
//   voices        packed signed 16-bit voices, voice i at [16i+15:16i]
//   gains         unsigned Q1.3 gain per voice (8 = unity), voice i at [4i+3:4i]
//   voice_en      per-voice enable; a disabled voice contributes zero
//   sig           signed mixed sample, held between updates
//   sample_valid  one-cycle pulse on each sig update
//   clip          set when the current sig was limited
//
// Optional build macro: MIX_SOFTCLIP_EN
//   defined   : magnitudes above SAT_KNEE are compressed 4:1 before the
//               16-bit hard limit; clip flags any magnitude above the knee
//   undefined : hard saturation only; SAT_KNEE is unused
module voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_DIV = 3200,
    parameter int SAT_KNEE   = 24576
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [16*NUM_VOICES-1:0] voices,
    input  logic [4*NUM_VOICES-1:0]  gains,
    input  logic [NUM_VOICES-1:0]    voice_en,
    output logic [15:0]             sig,
    output logic                    sample_valid,
    output logic                    clip
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam int AW = 18 + $clog2(NUM_VOICES) + 1;
    localparam int CW = $clog2(SAMPLE_DIV);

    localparam logic signed [AW-1:0] MAX_V = AW'(32767);
    localparam logic signed [AW-1:0] MIN_V = AW'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]           count;
    logic                    tick;
    logic [16*NUM_VOICES-1:0] v_q;
    logic [4*NUM_VOICES-1:0]  g_q;
    logic [NUM_VOICES-1:0]    en_q;
    logic [IW-1:0]           idx;
    logic signed [AW-1:0]    acc;

    logic signed [15:0]      cur_v;
    logic [3:0]              cur_g;
    logic                    cur_en;
    logic signed [20:0]      v_ext;
    logic signed [20:0]      g_ext;
    logic signed [20:0]      prod;
    logic signed [17:0]      term;
    logic signed [AW-1:0]    addend;

    logic signed [AW-1:0]    shaped;
    logic                    over_knee;
    logic [15:0]             sat_sig;
    logic                    sat_hit;

    // Free-running sample divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == CW'(SAMPLE_DIV - 1));

    // Single shared multiplier on the currently indexed snapshot voice
    always_comb begin
        cur_v  = v_q[int'(idx)*16 +: 16];
        cur_g  = g_q[int'(idx)*4 +: 4];
        cur_en = en_q[idx];
        v_ext  = {{5{cur_v[15]}}, cur_v};
        g_ext  = {17'b0, cur_g};
        prod   = v_ext * g_ext;
        // Arithmetic shift floors toward negative infinity
        term   = 18'(prod >>> 3);
        addend = cur_en ? {{(AW-18){term[17]}}, term} : '0;
    end

    // Output shaping and 16-bit limiting of the finished sum
    always_comb begin
        shaped    = acc;
        over_knee = 1'b0;
`ifdef MIX_SOFTCLIP_EN
        begin
            logic signed [AW-1:0] knee;
            logic signed [AW-1:0] mag;
            logic signed [AW-1:0] soft;
            knee = AW'(SAT_KNEE);
            mag  = acc[AW-1] ? -acc : acc;
            soft = knee + ((mag - knee) >>> 2);
            if (mag > knee) begin
                over_knee = 1'b1;
                shaped    = acc[AW-1] ? -soft : soft;
            end
        end
`endif
        sat_hit = 1'b0;
        sat_sig = shaped[15:0];
        if (shaped > MAX_V) begin
            sat_sig = 16'h7FFF;
            sat_hit = 1'b1;
        end else if (shaped < MIN_V) begin
            sat_sig = 16'h8000;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = ACCUM;
            ACCUM:   if (idx == IW'(NUM_VOICES - 1)) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q          <= '0;
            g_q          <= '0;
            en_q         <= '0;
            acc          <= '0;
            idx          <= '0;
            sig          <= '0;
            clip         <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        v_q  <= voices;
                        g_q  <= gains;
                        en_q <= voice_en;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                end
                OUT: begin
                    sig          <= sat_sig;
                    clip         <= sat_hit | over_knee;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The divider period leaves room for a full ACCUM/OUT pass between ticks
    a_tick_idle : assert property (@(posedge clk) disable iff (!rst_n)
        tick |-> state == IDLE);

    a_params : assert property (@(posedge clk)
        NUM_VOICES >= 2 && NUM_VOICES <= 16 &&
        SAMPLE_DIV > NUM_VOICES + 2 &&
        SAT_KNEE > 0 && SAT_KNEE < 32768);

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

    localparam int N   = 4;
    localparam int DIV = 3200;

    typedef int quad_t[4];

    typedef struct {
        quad_t      v;
        quad_t      g;
        logic [3:0] en;
        int         exp_sig;
        int         exp_clip;
        string      name;
    } vec_rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] voices = '0;
    logic [15:0] gains = '0;
    logic [3:0]  voice_en = '0;
    logic [15:0] sig;
    logic        sample_valid;
    logic        clip;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    voice_mixer #(
        .NUM_VOICES(N),
        .SAMPLE_DIV(DIV),
        .SAT_KNEE(24576)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .voices(voices),
        .gains(gains),
        .voice_en(voice_en),
        .sig(sig),
        .sample_valid(sample_valid),
        .clip(clip)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact floor(v*g/8) per voice, summed, then knee/limit rules
    function automatic void model(input quad_t v, input quad_t g, input logic [3:0] en,
                                  output int s, output int c);
        longint sum = 0;
        longint p, q, mag;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                p = longint'(v[i]) * longint'(g[i]);
                q = p / 8;
                if (p < 0 && (p % 8) != 0) q = q - 1;
                sum += q;
            end
        end
`ifdef MIX_SOFTCLIP_EN
        mag = (sum < 0) ? -sum : sum;
        if (mag > 24576) begin
            c = 1;
            mag = 24576 + (mag - 24576) / 4;
            sum = (sum < 0) ? -mag : mag;
        end
`else
        mag = 0;
`endif
        if (sum > 32767) begin
            sum = 32767;
            c = 1;
        end else if (sum < -32768) begin
            sum = -32768;
            c = 1;
        end
        s = int'(sum) + int'(mag) * 0;
    endfunction

    task automatic set_inputs(input quad_t v, input quad_t g, input logic [3:0] en);
        for (int i = 0; i < N; i++) begin
            voices[16*i +: 16] = 16'(v[i]);
            gains[4*i +: 4]    = 4'(g[i]);
        end
        voice_en = en;
    endtask

    task automatic wait_pulse(input string name);
        bit ok = 0;
        for (int k = 0; k < 2*DIV + N + 8; k++) begin
            @(negedge clk);
            if (sample_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no sample_valid expected pulse", name);
        end
    endtask

    task automatic check_out(input string name, input int es, input int ec);
        check({name, "_sig"}, int'($signed(sig)), es);
        check({name, "_clip"}, int'(clip), ec);
    endtask

    // Releases reset on a negedge and measures cycles to the first pulse
    task automatic release_and_time(input string name);
        int n = 0;
        bit ok = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 2*DIV + N + 8; k++) begin
            @(negedge clk);
            n++;
            if (sample_valid) begin
                ok = 1;
                break;
            end
        end
        check({name, "_latency"}, ok ? n : -1, DIV + N + 1);
    endtask

    // Period and hold monitor, sampled 1 time unit after each active edge
    bit          have_last = 0;
    bit          moved = 0;
    int          since = 0;
    logic [16:0] prev = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            have_last = 0;
            moved = 0;
            prev = {clip, sig};
        end else begin
            since++;
            if (sample_valid) begin
                if (have_last) begin
                    check("period", since, DIV);
                    check("held_between", int'(moved), 0);
                end
                have_last = 1;
                since = 0;
                moved = 0;
            end else if ({clip, sig} !== prev) begin
                moved = 1;
            end
            prev = {clip, sig};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    vec_rec_t tbl[10];
    quad_t    rv, rg, zq;
    logic [3:0] ren;
    int       es, ec;

    initial begin
        zq = '{0, 0, 0, 0};
        tbl[0] = '{'{1000, 0, 0, 0}, '{8, 0, 0, 0}, 4'b0001, 1000, 0, "unity"};
        tbl[1] = '{'{1000, 0, 0, 0}, '{4, 0, 0, 0}, 4'b0001, 500, 0, "half"};
        tbl[2] = '{'{-1001, 0, 0, 0}, '{4, 0, 0, 0}, 4'b0001, -501, 0, "floor"};
        tbl[3] = '{'{20000, 20000, 20000, 20000}, '{8, 8, 8, 8}, 4'b1111, 32767, 1, "sat_pos"};
        tbl[4] = '{'{-20000, -20000, -20000, -20000}, '{8, 8, 8, 8}, 4'b1111, -32768, 1, "sat_neg"};
        tbl[5] = '{'{1000, 1000, 1000, 1000}, '{8, 8, 8, 8}, 4'b0101, 2000, 0, "mask"};
        tbl[6] = '{'{30000, -30000, 12345, 777}, '{15, 15, 15, 15}, 4'b0000, 0, 0, "all_off"};
`ifdef MIX_SOFTCLIP_EN
        tbl[7] = '{'{20000, 20000, 0, 0}, '{8, 8, 0, 0}, 4'b0011, 28432, 1, "sum40000"};
`else
        tbl[7] = '{'{20000, 20000, 0, 0}, '{8, 8, 0, 0}, 4'b0011, 32767, 1, "sum40000"};
`endif
        tbl[8] = '{'{10000, 10000, 0, 0}, '{8, 8, 0, 0}, 4'b0011, 20000, 0, "sum20000"};
        tbl[9] = '{'{1000, -2000, 3, -3}, '{15, 15, 1, 1}, 4'b1111, -1876, 0, "gain15"};

        // Reset state
        repeat (3) @(negedge clk);
        check_out("reset", 0, 0);
        check("reset_valid", int'(sample_valid), 0);

        // First sample after release uses table row 0
        set_inputs(tbl[0].v, tbl[0].g, tbl[0].en);
        release_and_time("first");
        check_out(tbl[0].name, tbl[0].exp_sig, tbl[0].exp_clip);

        for (int r = 1; r < 10; r++) begin
            set_inputs(tbl[r].v, tbl[r].g, tbl[r].en);
            wait_pulse(tbl[r].name);
            check_out(tbl[r].name, tbl[r].exp_sig, tbl[r].exp_clip);
        end

        // Randomised mixes against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = int'($signed(16'($urandom_range(0, 65535))));
                rg[i] = int'($urandom_range(0, 15));
            end
            ren = 4'($urandom_range(0, 15));
            if (r == 0) ren = 4'b1111;
            model(rv, rg, ren, es, ec);
            set_inputs(rv, rg, ren);
            wait_pulse("rand");
            check_out("rand", es, ec);
        end

        // Inputs changed one cycle after the tick must not reach this sample
        set_inputs('{1000, 2000, 3000, 4000}, '{8, 8, 8, 8}, 4'b1111);
        repeat (DIV - N - 1) @(negedge clk);
        set_inputs('{-7, 0, 0, 0}, '{8, 0, 0, 0}, 4'b0001);
        wait_pulse("snap_old");
        check_out("snap_old", 10000, 0);
        wait_pulse("snap_new");
        check_out("snap_new", -7, 0);

        // Reset during ACCUM abandons the sample
        set_inputs(tbl[3].v, tbl[3].g, tbl[3].en);
        wait_pulse("pre_reset");
        check_out("pre_reset", 32767, 1);
        set_inputs('{1000, 1000, 1000, 0}, '{8, 8, 8, 0}, 4'b0111);
        repeat (DIV - N) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_out("mid_reset", 0, 0);
        check("mid_reset_valid", int'(sample_valid), 0);
        release_and_time("after_reset");
        check_out("after_reset", 3000, 0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
